// File: rtl/pwm_gen.sv
// pwm_gen: multi-channel 16-step PWM generator.
// A shared step counter runs 0..15 on divider ticks. Each channel keeps a
// software-written target duty and an active duty that only moves at period
// boundaries, either jumping to the target or ramping one step per period.
// All outputs are registered; no input reaches an output combinationally.

module pwm_gen #(
  parameter int N_CH    = 4,
  parameter int RAMP_EN = 1,
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            enable,
  input  logic            duty_wr,
  input  logic [CW-1:0]   duty_ch,
  input  logic [4:0]      duty_val,
  output logic [N_CH-1:0] pwm_out,
  output logic            period_start,
  output logic            ramping
);

  // Channel count widened by one bit so an index equal to N_CH can be rejected.
  localparam logic [CW:0] N_CH_W = N_CH[CW:0];

  logic [3:0]      step;
  logic [4:0]      target     [N_CH];
  logic [4:0]      active     [N_CH];
  logic [4:0]      active_nxt [N_CH];
  logic            boundary;
  logic            wr_hit;
  logic [4:0]      duty_clamped;
  logic [N_CH-1:0] pwm_nxt;
  logic            ramp_nxt;

  // A period boundary is the tick that moves step from 15 back to 0.
  assign boundary     = tick & enable & (step == 4'd15);
  assign duty_clamped = (duty_val > 5'd16) ? 5'd16 : duty_val;
  assign wr_hit       = duty_wr & ({1'b0, duty_ch} < N_CH_W);

  // Step counter; parked at 15 while disabled so the first tick after enable
  // always starts a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= 4'd15;
    end else if (!enable) begin
      step <= 4'd15;
    end else if (tick) begin
      step <= step + 4'd1;
    end
  end

  // Target shadow registers; writes land any cycle, enabled or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        target[i] <= 5'd0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_hit && (duty_ch == CW'(i))) begin
          target[i] <= duty_clamped;
        end
      end
    end
  end

  // Boundary value of each active duty: jump to target, or step one toward it.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      active_nxt[i] = active[i];
      if (RAMP_EN == 0) begin
        active_nxt[i] = target[i];
      end else if (active[i] < target[i]) begin
        active_nxt[i] = active[i] + 5'd1;
      end else if (active[i] > target[i]) begin
        active_nxt[i] = active[i] - 5'd1;
      end
    end
  end

  // Active duty registers; only touched at a boundary (the old target is used
  // when a write collides with the boundary) and cleared while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        active[i] <= 5'd0;
      end
    end else if (!enable) begin
      for (int i = 0; i < N_CH; i++) begin
        active[i] <= 5'd0;
      end
    end else if (boundary) begin
      for (int i = 0; i < N_CH; i++) begin
        active[i] <= active_nxt[i];
      end
    end
  end

  // Output compare and ramp detect from the registered step/active values.
  always_comb begin
    pwm_nxt  = '0;
    ramp_nxt = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      pwm_nxt[i] = enable & ({1'b0, step} < active[i]);
      ramp_nxt   = ramp_nxt | (active[i] != target[i]);
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      ramping      <= 1'b0;
    end else begin
      pwm_out      <= pwm_nxt;
      period_start <= boundary;
      ramping      <= ramp_nxt;
    end
  end

endmodule
